// File: rtl/cp0_v2.sv
// Coprocessor-0 for a small MIPS-style core: status/cause/EPC, trap entry,
// level interrupts and a Count/Compare timer.
module cp0_v2 #(
  parameter int          NUM_HWINT = 5,
  parameter logic [31:0] PRID_VAL  = 32'h0000_0B0A,
  parameter int          TIMER_EN  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           A1,
  input  logic [4:0]           A2,
  input  logic [31:0]          DIn,
  input  logic                 We,
  input  logic [31:0]          PC,
  input  logic                 ExcInBd,
  input  logic [4:0]           ExcCode,
  input  logic [31:0]          BadVAddrIn,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic                 Req,
  output logic [31:0]          EPCout,
  output logic [31:0]          DOut,
  output logic                 TimerIrq
);

  localparam bit TimerOn = (TIMER_EN != 0);

  logic [31:0] badvaddr_r;
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic [31:0] epc_r;
  logic [5:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic        bd_r;
  logic        ti_r;
  logic [4:0]  hw_ip_r;
  logic [4:0]  exccode_r;

  logic [4:0]  hwint_ext_s;
  logic [5:0]  pending_s;
  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;
  logic        wr_count_s;
  logic        wr_compare_s;
  logic        wr_sr_s;
  logic        wr_epc_s;
  logic        badv_load_s;
  logic [31:0] sr_val_s;
  logic [31:0] cause_val_s;

  // Trap request and write-enable decode; any mtc0 is dropped while a trap is taken.
  always_comb begin
    hwint_ext_s  = 5'(HWInt);
    pending_s    = {ti_r, hwint_ext_s};
    int_req_s    = (|(pending_s & im_r)) & ie_r & ~exl_r;
    exc_req_s    = (ExcCode != 5'd0) & ~exl_r;
    req_s        = (int_req_s | exc_req_s) & ~rst;
    wr_count_s   = We & (A2 == 5'd9)  & ~req_s & TimerOn;
    wr_compare_s = We & (A2 == 5'd11) & ~req_s & TimerOn;
    wr_sr_s      = We & (A2 == 5'd12) & ~req_s;
    wr_epc_s     = We & (A2 == 5'd14) & ~req_s;
    badv_load_s  = req_s & ~int_req_s & ((ExcCode == 5'd4) | (ExcCode == 5'd5));
  end

  // Free-running Count, Compare and the sticky timer interrupt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= 32'd0;
      compare_r <= 32'hFFFF_FFFF;
      ti_r      <= 1'b0;
    end else if (!TimerOn) begin
      count_r   <= 32'd0;
      ti_r      <= 1'b0;
    end else begin
      count_r <= wr_count_s ? DIn : count_r + 32'd1;
      if (wr_compare_s) begin
        compare_r <= DIn;
        ti_r      <= 1'b0;
      end else if (count_r == compare_r) begin
        ti_r <= 1'b1;
      end
    end
  end

  // Status register: trap entry forces EXL, eret clears it even over an mtc0.
  always_ff @(posedge clk) begin
    if (rst) begin
      im_r  <= 6'd0;
      exl_r <= 1'b0;
      ie_r  <= 1'b0;
    end else if (req_s) begin
      exl_r <= 1'b1;
    end else if (wr_sr_s) begin
      im_r  <= DIn[15:10];
      ie_r  <= DIn[0];
      exl_r <= DIn[1] & ~EXLClr;
    end else if (EXLClr) begin
      exl_r <= 1'b0;
    end
  end

  // Cause, EPC and BadVAddr capture at trap entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      bd_r       <= 1'b0;
      exccode_r  <= 5'd0;
      hw_ip_r    <= 5'd0;
      epc_r      <= 32'd0;
      badvaddr_r <= 32'd0;
    end else begin
      hw_ip_r <= hwint_ext_s;
      if (req_s) begin
        bd_r      <= ExcInBd;
        exccode_r <= int_req_s ? 5'd0 : ExcCode;
        epc_r     <= ExcInBd ? (PC - 32'd4) : PC;
      end else if (wr_epc_s) begin
        epc_r <= DIn;
      end
      if (badv_load_s) begin
        badvaddr_r <= BadVAddrIn;
      end
    end
  end

  // Read mux over pre-edge register state.
  always_comb begin
    sr_val_s    = {16'h0000, im_r, 8'h00, exl_r, ie_r};
    cause_val_s = {bd_r, ti_r, 14'h0000, ti_r, hw_ip_r, 3'b000, exccode_r, 2'b00};
    case (A1)
      5'd8:    DOut = badvaddr_r;
      5'd9:    DOut = TimerOn ? count_r : 32'd0;
      5'd11:   DOut = TimerOn ? compare_r : 32'd0;
      5'd12:   DOut = sr_val_s;
      5'd13:   DOut = cause_val_s;
      5'd14:   DOut = epc_r;
      5'd15:   DOut = PRID_VAL;
      default: DOut = 32'd0;
    endcase
  end

  assign Req      = req_s;
  assign EPCout   = epc_r;
  assign TimerIrq = ti_r;

endmodule

// File: tb/tb_cp0_v2.sv
// Directed bench for cp0_v2: trap entry, eret, timer wrap/interrupt and
// same-cycle collision rules, with hand-computed expectations.
module tb_cp0_v2;

  logic        clk;
  logic        rst;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic        ExcInBd;
  logic [4:0]  ExcCode;
  logic [31:0] BadVAddrIn;
  logic [4:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCout;
  logic [31:0] DOut;
  logic        TimerIrq;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_v2 dut (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .DIn(DIn), .We(We), .PC(PC),
    .ExcInBd(ExcInBd), .ExcCode(ExcCode), .BadVAddrIn(BadVAddrIn),
    .HWInt(HWInt), .EXLClr(EXLClr), .Req(Req), .EPCout(EPCout),
    .DOut(DOut), .TimerIrq(TimerIrq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    A1 = addr;
    #1;
    check_eq(tag, DOut, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] val);
    We = 1'b1; A2 = addr; DIn = val;
    tick();
    We = 1'b0;
  endtask

  initial begin
    rst = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; We = 1'b0; PC = 32'd0;
    ExcInBd = 1'b0; ExcCode = 5'd0; BadVAddrIn = 32'd0; HWInt = 5'd0; EXLClr = 1'b0;
    tick();
    tick();
    ExcCode = 5'd10;
    #1;
    check_eq("rst_req", {31'd0, Req}, 32'd0);
    ExcCode = 5'd0;
    check_eq("rst_ti", {31'd0, TimerIrq}, 32'd0);
    check_eq("rst_epcout", EPCout, 32'd0);
    check_reg("rst_sr", 5'd12, 32'd0);
    check_reg("rst_cause", 5'd13, 32'd0);
    check_reg("rst_epc", 5'd14, 32'd0);
    check_reg("rst_compare", 5'd11, 32'hFFFF_FFFF);
    check_reg("rst_count", 5'd9, 32'd0);
    check_reg("rst_badv", 5'd8, 32'd0);
    check_reg("prid", 5'd15, 32'h0000_0B0A);
    check_reg("unmapped", 5'd10, 32'd0);
    rst = 1'b0;
    tick();

    // Plain exception entry
    ExcCode = 5'd10; PC = 32'h3008;
    #1;
    check_eq("exc_req", {31'd0, Req}, 32'd1);
    tick();
    ExcCode = 5'd0;
    #1;
    check_eq("exc_req_drop", {31'd0, Req}, 32'd0);
    check_eq("exc_epcout", EPCout, 32'h3008);
    check_reg("exc_sr", 5'd12, 32'h2);
    check_reg("exc_cause", 5'd13, 32'h28);
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    check_reg("eret_sr", 5'd12, 32'd0);

    // Interrupt beats a simultaneous AdEL in a delay slot
    mtc0(5'd12, 32'h0401);
    check_reg("sr_wr", 5'd12, 32'h0401);
    HWInt = 5'b00001; ExcCode = 5'd4; ExcInBd = 1'b1; PC = 32'h3010; BadVAddrIn = 32'hDEAD_BEEF;
    #1;
    check_eq("int_req", {31'd0, Req}, 32'd1);
    tick();
    HWInt = 5'd0; ExcCode = 5'd0; ExcInBd = 1'b0;
    check_reg("int_cause", 5'd13, 32'h8000_0400);
    check_reg("int_epc", 5'd14, 32'h300C);
    check_reg("int_badv_hold", 5'd8, 32'd0);
    check_reg("int_sr", 5'd12, 32'h0403);
    ExcCode = 5'd7;
    #1;
    check_eq("exl_blocks", {31'd0, Req}, 32'd0);
    ExcCode = 5'd0;

    // AdES captures BadVAddr
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    ExcCode = 5'd5; BadVAddrIn = 32'h1001; PC = 32'h3020;
    #1;
    check_eq("ades_req", {31'd0, Req}, 32'd1);
    tick();
    ExcCode = 5'd0;
    check_reg("ades_badv", 5'd8, 32'h1001);
    check_reg("ades_cause", 5'd13, 32'h14);
    check_reg("ades_epc", 5'd14, 32'h3020);
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    check_reg("ades_eret", 5'd12, 32'h0401);

    // Timer wrap and interrupt
    mtc0(5'd11, 32'h1);
    mtc0(5'd9, 32'hFFFF_FFFE);
    check_reg("cnt_load", 5'd9, 32'hFFFF_FFFE);
    check_eq("ti_e1", {31'd0, TimerIrq}, 32'd0);
    tick();
    check_reg("cnt_max", 5'd9, 32'hFFFF_FFFF);
    tick();
    check_reg("cnt_wrap", 5'd9, 32'd0);
    tick();
    check_reg("cnt_one", 5'd9, 32'd1);
    check_eq("ti_e4", {31'd0, TimerIrq}, 32'd0);
    tick();
    check_eq("ti_e5", {31'd0, TimerIrq}, 32'd1);
    check_reg("ti_cause", 5'd13, 32'h4000_8014);
    tick();
    check_eq("ti_sticky", {31'd0, TimerIrq}, 32'd1);
    mtc0(5'd12, 32'h8001);
    check_reg("sr_timer", 5'd12, 32'h8001);
    We = 1'b1; A2 = 5'd11; DIn = 32'h55; PC = 32'h4000;
    #1;
    check_eq("ti_req", {31'd0, Req}, 32'd1);
    tick();
    We = 1'b0;
    check_eq("cmp_drop_ti", {31'd0, TimerIrq}, 32'd1);
    check_reg("cmp_drop", 5'd11, 32'h1);
    check_reg("ti_int_cause", 5'd13, 32'h4000_8000);
    check_reg("ti_int_epc", 5'd14, 32'h4000);
    check_reg("ti_int_sr", 5'd12, 32'h8003);
    mtc0(5'd11, 32'h100);
    check_eq("cmp_clr_ti", {31'd0, TimerIrq}, 32'd0);
    check_reg("cmp_wr", 5'd11, 32'h100);

    // Trap with simultaneous mtc0 SR and eret
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    check_reg("sr_after_eret", 5'd12, 32'h8001);
    check_eq("no_req", {31'd0, Req}, 32'd0);
    ExcCode = 5'd8; We = 1'b1; A2 = 5'd12; DIn = 32'd0; EXLClr = 1'b1; PC = 32'h5000;
    #1;
    check_eq("col_req", {31'd0, Req}, 32'd1);
    tick();
    We = 1'b0; EXLClr = 1'b0; ExcCode = 5'd0;
    check_reg("col_sr", 5'd12, 32'h8003);
    check_reg("col_cause", 5'd13, 32'h20);
    check_reg("col_epc", 5'd14, 32'h5000);

    // eret with mtc0 SR: EXL ends 0
    EXLClr = 1'b1;
    mtc0(5'd12, 32'h0403);
    EXLClr = 1'b0;
    check_reg("eret_mtc0_sr", 5'd12, 32'h0401);
    mtc0(5'd14, 32'h1234_5677);
    check_eq("epc_wr", EPCout, 32'h1234_5677);

    // Delay-slot PC-4 wraps modulo 2^32
    ExcCode = 5'd12; ExcInBd = 1'b1; PC = 32'd0;
    #1;
    check_eq("wrap_req", {31'd0, Req}, 32'd1);
    tick();
    ExcCode = 5'd0; ExcInBd = 1'b0;
    check_eq("wrap_epc", EPCout, 32'hFFFF_FFFC);
    check_reg("wrap_cause", 5'd13, 32'h8000_0030);

    // Count write dropped under trap, still increments
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    mtc0(5'd9, 32'h1000);
    check_reg("cnt_wr", 5'd9, 32'h1000);
    We = 1'b1; A2 = 5'd9; DIn = 32'h777; ExcCode = 5'd3;
    #1;
    check_eq("cnt_col_req", {31'd0, Req}, 32'd1);
    tick();
    We = 1'b0; ExcCode = 5'd0;
    check_reg("cnt_drop", 5'd9, 32'h1001);

    // Reset during a trap overrides everything
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rst = 1'b1; ExcCode = 5'd4; HWInt = 5'b00001; BadVAddrIn = 32'hABCD;
    #1;
    check_eq("rst_trap_req", {31'd0, Req}, 32'd0);
    tick();
    rst = 1'b0; ExcCode = 5'd0; HWInt = 5'd0;
    check_reg("rst2_sr", 5'd12, 32'd0);
    check_reg("rst2_cause", 5'd13, 32'd0);
    check_reg("rst2_epc", 5'd14, 32'd0);
    check_reg("rst2_badv", 5'd8, 32'd0);
    check_reg("rst2_compare", 5'd11, 32'hFFFF_FFFF);
    check_eq("rst2_ti", {31'd0, TimerIrq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
